// File: rtl/player_step_ctrl.sv
// Frame-rate player motion controller: one turn or one collision-checked grid step per frame tick.
// Optional STEP_STATS_EN adds a saturating blocked-step counter output.
module player_step_ctrl #(
  parameter int unsigned MAP_W     = 16,
  parameter int unsigned MAP_H     = 16,
  parameter int unsigned COORD_W   = 4,
  parameter int unsigned START_X   = 1,
  parameter int unsigned START_Y   = 1,
  parameter int unsigned START_DIR = 0
) (
  input  logic               clkin,
  input  logic               reset,
  input  logic               frame_clk,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_fwd,
  input  logic               btn_back,
  output logic               map_req,
  output logic [COORD_W-1:0] map_x,
  output logic [COORD_W-1:0] map_y,
  input  logic               map_ack,
  input  logic               map_wall,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic [1:0]         heading,
  output logic               moved,
  output logic               busy
`ifdef STEP_STATS_EN
  ,
  output logic [7:0]         blocked_cnt
`endif
);

  typedef enum logic [0:0] {StIdle, StLookup} state_e;

  localparam logic [COORD_W:0] MapWLim = (COORD_W+1)'(MAP_W);
  localparam logic [COORD_W:0] MapHLim = (COORD_W+1)'(MAP_H);
  localparam logic [COORD_W:0] One     = (COORD_W+1)'(1);

  state_e             state_q, state_d;
  logic               frame_prev_q;
  logic [COORD_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [COORD_W-1:0] map_x_q, map_x_d, map_y_q, map_y_d;
  logic [1:0]         heading_q, heading_d;
  logic               map_req_q, map_req_d, moved_q, moved_d, busy_q, busy_d;

  logic               tick;
  logic [1:0]         step_dir;
  logic [COORD_W:0]   tgt_x, tgt_y;
  logic               oob;

  assign tick     = frame_clk & ~frame_prev_q;
  // Back steps walk the opposite heading; fwd wins when both are pressed.
  assign step_dir = btn_fwd ? heading_q : heading_q + 2'd2;

  // Target is one bit wider so underflow shows up in the top bit.
  always_comb begin
    tgt_x = {1'b0, pos_x_q};
    tgt_y = {1'b0, pos_y_q};
    unique case (step_dir)
      2'd0: tgt_y = tgt_y - One;
      2'd1: tgt_x = tgt_x + One;
      2'd2: tgt_y = tgt_y + One;
      2'd3: tgt_x = tgt_x - One;
      default: ;
    endcase
    oob = tgt_x[COORD_W] | tgt_y[COORD_W] | (tgt_x >= MapWLim) | (tgt_y >= MapHLim);
  end

  always_comb begin
    state_d   = state_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    map_x_d   = map_x_q;
    map_y_d   = map_y_q;
    heading_d = heading_q;
    map_req_d = map_req_q;
    busy_d    = busy_q;
    moved_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tick) begin
          if (btn_left) begin
            heading_d = heading_q - 2'd1;
          end else if (btn_right) begin
            heading_d = heading_q + 2'd1;
          end else if ((btn_fwd | btn_back) && !oob) begin
            map_x_d   = tgt_x[COORD_W-1:0];
            map_y_d   = tgt_y[COORD_W-1:0];
            map_req_d = 1'b1;
            busy_d    = 1'b1;
            state_d   = StLookup;
          end
        end
      end
      StLookup: begin
        if (map_ack) begin
          map_req_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = StIdle;
          if (!map_wall) begin
            pos_x_d = map_x_q;
            pos_y_d = map_y_q;
            moved_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q      <= StIdle;
      frame_prev_q <= 1'b1;
      pos_x_q      <= COORD_W'(START_X);
      pos_y_q      <= COORD_W'(START_Y);
      heading_q    <= 2'(START_DIR);
      map_x_q      <= '0;
      map_y_q      <= '0;
      map_req_q    <= 1'b0;
      moved_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_prev_q <= frame_clk;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      heading_q    <= heading_d;
      map_x_q      <= map_x_d;
      map_y_q      <= map_y_d;
      map_req_q    <= map_req_d;
      moved_q      <= moved_d;
      busy_q       <= busy_d;
    end
  end

  assign map_req = map_req_q;
  assign map_x   = map_x_q;
  assign map_y   = map_y_q;
  assign pos_x   = pos_x_q;
  assign pos_y   = pos_y_q;
  assign heading = heading_q;
  assign moved   = moved_q;
  assign busy    = busy_q;

`ifdef STEP_STATS_EN
  logic [7:0] blocked_cnt_q, blocked_cnt_d;
  logic       blocked;

  assign blocked = ((state_q == StIdle) && tick && !btn_left && !btn_right &&
                    (btn_fwd || btn_back) && oob) ||
                   ((state_q == StLookup) && map_ack && map_wall);

  always_comb begin
    blocked_cnt_d = blocked_cnt_q;
    if (blocked && (blocked_cnt_q != 8'hff)) blocked_cnt_d = blocked_cnt_q + 8'd1;
  end

  always_ff @(posedge clkin) begin
    if (reset) blocked_cnt_q <= 8'd0;
    else       blocked_cnt_q <= blocked_cnt_d;
  end

  assign blocked_cnt = blocked_cnt_q;
`endif

endmodule

// File: tb/tb_player_step_ctrl.sv
// Directed self-checking bench for player_step_ctrl; a second instance starts at (15,3) facing E.
module tb_player_step_ctrl;
  logic clk = 1'b0;
  logic reset, frame_clk, btn_left, btn_right, btn_fwd, btn_back, map_ack, map_wall;
  logic map_req, moved, busy;
  logic [3:0] map_x, map_y, pos_x, pos_y;
  logic [1:0] heading;

  logic frame_clk2, btn_fwd2, map_ack2;
  logic map_req2, moved2, busy2;
  logic [3:0] map_x2, map_y2, pos_x2, pos_y2;
  logic [1:0] heading2;
`ifdef STEP_STATS_EN
  logic [7:0] blocked_cnt, blocked_cnt2;
`endif

  int checks = 0;
  int errors = 0;
  logic seen_req;

  always #5 clk = ~clk;

  player_step_ctrl dut (
    .clkin(clk), .reset(reset), .frame_clk(frame_clk),
    .btn_left(btn_left), .btn_right(btn_right), .btn_fwd(btn_fwd), .btn_back(btn_back),
    .map_req(map_req), .map_x(map_x), .map_y(map_y), .map_ack(map_ack), .map_wall(map_wall),
    .pos_x(pos_x), .pos_y(pos_y), .heading(heading), .moved(moved), .busy(busy)
`ifdef STEP_STATS_EN
    , .blocked_cnt(blocked_cnt)
`endif
  );

  player_step_ctrl #(.START_X(15), .START_Y(3), .START_DIR(1)) dut2 (
    .clkin(clk), .reset(reset), .frame_clk(frame_clk2),
    .btn_left(1'b0), .btn_right(1'b0), .btn_fwd(btn_fwd2), .btn_back(1'b0),
    .map_req(map_req2), .map_x(map_x2), .map_y(map_y2), .map_ack(map_ack2), .map_wall(1'b0),
    .pos_x(pos_x2), .pos_y(pos_y2), .heading(heading2), .moved(moved2), .busy(busy2)
`ifdef STEP_STATS_EN
    , .blocked_cnt(blocked_cnt2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One frame: low for a cycle, then the rising level is seen at the following edge.
  task automatic tick1();
    frame_clk = 1'b0;
    cyc();
    frame_clk = 1'b1;
    cyc();
  endtask

  task automatic turn(input logic l, input logic r);
    btn_left = l; btn_right = r;
    tick1();
    btn_left = 1'b0; btn_right = 1'b0;
  endtask

  // Step with an immediate acknowledge on the first lookup cycle.
  task automatic go(input logic f, input logic b, input logic wall);
    btn_fwd = f; btn_back = b;
    tick1();
    btn_fwd = 1'b0; btn_back = 1'b0;
    chk("go_req_on", {31'd0, map_req}, 1);
    map_ack = 1'b1; map_wall = wall;
    cyc();
    map_ack = 1'b0; map_wall = 1'b0;
    chk("go_req_off", {31'd0, map_req}, 0);
  endtask

  initial begin
    reset = 1'b1; frame_clk = 1'b1; btn_left = 0; btn_right = 0; btn_fwd = 0; btn_back = 0;
    map_ack = 0; map_wall = 0; frame_clk2 = 1'b1; btn_fwd2 = 0; map_ack2 = 0;
    cyc(); cyc();
    reset = 1'b0;

    // Reset state, frame_clk high across reset release gives no tick
    seen_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      seen_req |= map_req;
    end
    chk("rst_no_req", {31'd0, seen_req}, 0);
    chk("rst_pos_x", {28'd0, pos_x}, 1);
    chk("rst_pos_y", {28'd0, pos_y}, 1);
    chk("rst_heading", {30'd0, heading}, 0);
    chk("rst_map_x", {28'd0, map_x}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_moved", {31'd0, moved}, 0);
    chk("rst2_pos_x", {28'd0, pos_x2}, 15);
    chk("rst2_heading", {30'd0, heading2}, 1);
`ifdef STEP_STATS_EN
    chk("rst_blocked", {24'd0, blocked_cnt}, 0);
`endif

    // Left held for 4 ticks: heading wraps 3,2,1,0
    btn_left = 1'b1;
    tick1(); chk("left1", {30'd0, heading}, 3); chk("left1_req", {31'd0, map_req}, 0);
    tick1(); chk("left2", {30'd0, heading}, 2);
    tick1(); chk("left3", {30'd0, heading}, 1);
    tick1(); chk("left4", {30'd0, heading}, 0); chk("left4_req", {31'd0, map_req}, 0);
    btn_left = 1'b0;

    // Face E, step forward with a delayed, clear acknowledge
    turn(0, 1);
    chk("right_e", {30'd0, heading}, 1);
    btn_fwd = 1'b1;
    tick1();
    btn_fwd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wait_req", {31'd0, map_req}, 1);
      chk("wait_busy", {31'd0, busy}, 1);
      chk("wait_map_x", {28'd0, map_x}, 2);
      chk("wait_map_y", {28'd0, map_y}, 1);
      chk("wait_pos_x", {28'd0, pos_x}, 1);
      if (i < 2) cyc();
    end
    map_ack = 1'b1; map_wall = 1'b0;
    cyc();
    map_ack = 1'b0;
    chk("ack_pos_x", {28'd0, pos_x}, 2);
    chk("ack_pos_y", {28'd0, pos_y}, 1);
    chk("ack_moved", {31'd0, moved}, 1);
    chk("ack_busy", {31'd0, busy}, 0);
    chk("ack_req", {31'd0, map_req}, 0);
    cyc();
    chk("moved_once", {31'd0, moved}, 0);

    // Wall in the way at (3,1)
    go(1, 0, 1);
    chk("wall_pos_x", {28'd0, pos_x}, 2);
    chk("wall_moved", {31'd0, moved}, 0);
    chk("wall_busy", {31'd0, busy}, 0);
`ifdef STEP_STATS_EN
    chk("wall_blocked", {24'd0, blocked_cnt}, 1);
`endif

    // Back to (1,1), then walk to (0,0) and try to leave the map northwards
    go(0, 1, 0);
    chk("back_pos_x", {28'd0, pos_x}, 1);
    turn(1, 0);
    go(1, 0, 0);
    chk("n_pos_y", {28'd0, pos_y}, 0);
    turn(1, 0);
    chk("face_w", {30'd0, heading}, 3);
    go(1, 0, 0);
    chk("w_pos_x", {28'd0, pos_x}, 0);
    turn(0, 1);
    btn_fwd = 1'b1;
    tick1();
    btn_fwd = 1'b0;
    chk("oob_n_req", {31'd0, map_req}, 0);
    chk("oob_n_busy", {31'd0, busy}, 0);
    chk("oob_n_pos_x", {28'd0, pos_x}, 0);
    chk("oob_n_pos_y", {28'd0, pos_y}, 0);
`ifdef STEP_STATS_EN
    chk("oob_blocked", {24'd0, blocked_cnt}, 2);
`endif

    // Second instance at (15,3) facing E: right edge blocks
    btn_fwd2 = 1'b1;
    frame_clk2 = 1'b0; cyc(); frame_clk2 = 1'b1; cyc();
    btn_fwd2 = 1'b0;
    chk("oob_e_req", {31'd0, map_req2}, 0);
    chk("oob_e_busy", {31'd0, busy2}, 0);
    chk("oob_e_pos_x", {28'd0, pos_x2}, 15);
    chk("oob_e_pos_y", {28'd0, pos_y2}, 3);
`ifdef STEP_STATS_EN
    chk("oob_e_blocked", {24'd0, blocked_cnt2}, 1);
`endif

    // Outstanding request, dropped second tick, reset, then a late ack
    turn(0, 1);
    btn_fwd = 1'b1;
    tick1();
    chk("mid_req", {31'd0, map_req}, 1);
    chk("mid_map_x", {28'd0, map_x}, 1);
    tick1();
    chk("drop_req", {31'd0, map_req}, 1);
    chk("drop_map_x", {28'd0, map_x}, 1);
    chk("drop_map_y", {28'd0, map_y}, 0);
    chk("drop_pos_x", {28'd0, pos_x}, 0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rr_req", {31'd0, map_req}, 0);
    chk("rr_busy", {31'd0, busy}, 0);
    chk("rr_map_x", {28'd0, map_x}, 0);
    chk("rr_pos_x", {28'd0, pos_x}, 1);
    chk("rr_pos_y", {28'd0, pos_y}, 1);
    chk("rr_heading", {30'd0, heading}, 0);
    map_ack = 1'b1;
    cyc();
    map_ack = 1'b0;
    btn_fwd = 1'b0;
    chk("late_pos_x", {28'd0, pos_x}, 1);
    chk("late_pos_y", {28'd0, pos_y}, 1);
    chk("late_moved", {31'd0, moved}, 0);
    chk("late_req", {31'd0, map_req}, 0);
`ifdef STEP_STATS_EN
    chk("late_blocked", {24'd0, blocked_cnt}, 0);
`endif
    cyc();
    chk("late_moved2", {31'd0, moved}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/player_step_ctrl.md
Name: player_step_ctrl

Overview:
- Frame-rate player motion controller for the raycast maze. Directly downstream of the rate divider: consumes its toggling slow clock output as a frame tick.
- On each frame it samples the player buttons and applies one turn or one grid step.
- Steps are collision-checked against the maze map through a request/acknowledge port.
- Registered position and heading feed the raycaster.

Parameters:
- MAP_W, 16, maze width in cells.
- MAP_H, 16, maze height in cells.
- COORD_W, 4, width of the x and y cell coordinates; must satisfy 2^COORD_W >= max(MAP_W, MAP_H).
- START_X, 1, reset x cell.
- START_Y, 1, reset y cell.
- START_DIR, 0, reset heading (0=N, 1=E, 2=S, 3=W).

Ports:
- clkin  input  1  system clock, 50 MHz
- reset  input  1  synchronous, active-high
- frame_clk  input  1  toggling output of the rate divider; each rising level change is one frame tick
- btn_left  input  1  turn counter-clockwise
- btn_right  input  1  turn clockwise
- btn_fwd  input  1  step along heading
- btn_back  input  1  step against heading
- map_req  output  1  map lookup request
- map_x  output  COORD_W  lookup cell x
- map_y  output  COORD_W  lookup cell y
- map_ack  input  1  map response valid
- map_wall  input  1  1 = target cell is a wall; valid when map_ack=1
- pos_x  output  COORD_W  player cell x
- pos_y  output  COORD_W  player cell y
- heading  output  2  player heading
- moved  output  1  one-cycle pulse after a committed step
- busy  output  1  high while a lookup is outstanding

Behaviour:
- Reset values: pos_x=START_X, pos_y=START_Y, heading=START_DIR, map_req=0, map_x=0, map_y=0, moved=0, busy=0, state=IDLE, frame_prev=1. Because frame_prev resets to 1, a frame_clk that is high at reset release does not produce a tick.
- Tick detection: frame_prev registers frame_clk every cycle. tick = frame_clk & ~frame_prev. frame_clk is already in the clkin domain, so no synchronizer is used.
- States: IDLE, LOOKUP.
- IDLE with tick: decide on the buttons sampled in the same cycle, priority left > right > fwd > back.
  - Turn: heading <= heading-1 (left) or heading+1 (right), modulo 4 (N-1 wraps to W). Visible the next cycle. State stays IDLE.
  - Step: the target is one cell along the heading (N: y-1, E: x+1, S: y+1, W: x-1); back uses the opposite direction.
    - Out of bounds (x or y < 0, x >= MAP_W, y >= MAP_H; detect on a COORD_W+1 signed value): step blocked, no request, state stays IDLE.
    - In bounds: map_x/map_y <= target, map_req <= 1, busy <= 1, state <= LOOKUP.
  - No button pressed: nothing happens.
- LOOKUP:
  - map_req, map_x and map_y are held stable until map_ack is sampled high.
  - On that edge: map_req <= 0 and busy <= 0. If map_wall=0, pos <= target and moved <= 1 for exactly the next cycle; otherwise the step is blocked. State <= IDLE.
  - Minimum latency from tick edge to pos update is 2 cycles (ack on the first LOOKUP cycle).
- Ticks arriving while in LOOKUP are dropped, not queued. map_ack while map_req=0 is ignored.
- Buttons are not debounced here. One action is taken per tick while a button is held.
- Reset mid-lookup: at the next edge map_req=0 and all outputs return to their reset values. A late map_ack is then ignored.

Optional Feature:
- Macro: STEP_STATS_EN.
- Defined: adds output blocked_cnt [7:0], reset to 0. It increments by 1 on each blocked step (out-of-bounds or wall) and saturates at 255. Turns never count.
- Undefined: the port and counter are absent. Blocked steps are otherwise identical.

Test Plan:
- Reset with frame_clk=1, then hold frame_clk high for 10 cycles -> no tick; pos=(1,1), heading=0, map_req never asserts.
- heading=0, btn_left held, 4 ticks -> heading goes 3,2,1,0 (wrap verified); map_req stays 0.
- pos (1,1), heading E, btn_fwd, ack 3 cycles after request with map_wall=0 -> map_x=2, map_y=1 stable while waiting; pos=(2,1); single moved pulse; busy high for exactly the lookup.
- Same as above with map_wall=1 -> pos unchanged, no moved pulse. With STEP_STATS_EN, blocked_cnt=1.
- pos (0,0), heading N, btn_fwd -> no map_req, pos stays (0,0). Also pos (15,3), heading E -> blocked.
- Request outstanding, second tick arrives, then reset asserted before ack, then ack -> second tick dropped; map_req=0 the cycle after reset; pos=(1,1); late ack has no effect.
